// File: rtl/reg_bus_decoder.sv
// Register-bus address decoder: routes single-outstanding bridge accesses to N_SLV
// regions by address field, with per-access timeout watchdog and error counting.
module reg_bus_decoder #(
  parameter int unsigned AXI_ADDR_WIDTH = 32,
  parameter int unsigned AXI_DATA_WIDTH = 32,
  parameter int unsigned N_SLV          = 4,
  parameter int unsigned SEL_LSB        = 12,
  parameter int unsigned TIMEOUT        = 255,
  parameter logic [AXI_DATA_WIDTH-1:0] ERR_DATA = 32'hDEADBEEF
) (
  input  logic                              s_axi_aclk,
  input  logic                              s_axi_areset,
  input  logic                              wr_en,
  input  logic                              rd_en,
  input  logic [AXI_ADDR_WIDTH-1:0]         waddr,
  input  logic [AXI_ADDR_WIDTH-1:0]         raddr,
  input  logic [AXI_DATA_WIDTH-1:0]         wdata,
  input  logic [AXI_DATA_WIDTH/8-1:0]       wstrb,
  output logic [AXI_DATA_WIDTH-1:0]         rdata,
  output logic                              wr_ack,
  output logic                              rd_ack,
  output logic [N_SLV-1:0]                  slv_wr_en,
  output logic [N_SLV-1:0]                  slv_rd_en,
  output logic [SEL_LSB-1:0]                slv_addr,
  output logic [AXI_DATA_WIDTH-1:0]         slv_wdata,
  output logic [AXI_DATA_WIDTH/8-1:0]       slv_wstrb,
  input  logic [N_SLV*AXI_DATA_WIDTH-1:0]   slv_rdata,
  input  logic [N_SLV-1:0]                  slv_wr_ack,
  input  logic [N_SLV-1:0]                  slv_rd_ack,
  output logic [15:0]                       err_cnt
);

  localparam int unsigned      DW     = AXI_DATA_WIDTH;
  localparam int unsigned      SW     = AXI_DATA_WIDTH / 8;
  localparam logic [4:0]       NSLV5  = 5'(N_SLV);
  localparam logic [15:0]      TO16   = 16'(TIMEOUT);
  localparam logic [N_SLV-1:0] ONEHOT = N_SLV'(1);

  typedef enum logic [1:0] {IDLE, WR_WAIT, RD_WAIT, DONE} state_t;

  state_t                    state, state_n;
  logic                      pend_wr, pend_wr_n;
  logic                      pend_rd, pend_rd_n;
  logic [AXI_ADDR_WIDTH-1:0] pw_addr, pw_addr_n;
  logic [DW-1:0]             pw_data, pw_data_n;
  logic [SW-1:0]             pw_strb, pw_strb_n;
  logic [AXI_ADDR_WIDTH-1:0] pr_addr, pr_addr_n;
  logic [3:0]                sel_q, sel_n;
  logic                      unmap_q, unmap_n;
  logic [15:0]               tcnt, tcnt_n;

  logic [DW-1:0]             rdata_n;
  logic                      wr_ack_n, rd_ack_n;
  logic [N_SLV-1:0]          slv_wr_en_n, slv_rd_en_n;
  logic [SEL_LSB-1:0]        slv_addr_n;
  logic [DW-1:0]             slv_wdata_n;
  logic [SW-1:0]             slv_wstrb_n;
  logic [15:0]               err_cnt_n;

  logic [AXI_ADDR_WIDTH-1:0] go_addr;
  logic [3:0]                go_sel;
  logic                      go_unmap;
  logic                      err_inc;
  logic                      sel_wack, sel_rack, sel_ack;
  logic [DW-1:0]             sel_rdata;

  // Only the latched region's ack/data are visible; unmapped selects match nothing.
  always_comb begin
    sel_wack  = 1'b0;
    sel_rack  = 1'b0;
    sel_rdata = '0;
    for (int unsigned i = 0; i < N_SLV; i++) begin
      if (sel_q == 4'(i)) begin
        sel_wack  = slv_wr_ack[i];
        sel_rack  = slv_rd_ack[i];
        sel_rdata = slv_rdata[i*DW +: DW];
      end
    end
    sel_ack = (state == WR_WAIT) ? sel_wack : sel_rack;
  end

  always_comb begin
    state_n     = state;
    pend_wr_n   = pend_wr;
    pend_rd_n   = pend_rd;
    pw_addr_n   = pw_addr;
    pw_data_n   = pw_data;
    pw_strb_n   = pw_strb;
    pr_addr_n   = pr_addr;
    sel_n       = sel_q;
    unmap_n     = unmap_q;
    tcnt_n      = tcnt;
    rdata_n     = rdata;
    wr_ack_n    = 1'b0;
    rd_ack_n    = 1'b0;
    slv_wr_en_n = '0;
    slv_rd_en_n = '0;
    slv_addr_n  = slv_addr;
    slv_wdata_n = slv_wdata;
    slv_wstrb_n = slv_wstrb;
    err_inc     = 1'b0;
    go_addr     = '0;
    go_sel      = '0;
    go_unmap    = 1'b0;

    unique case (state)
      // DONE launches like IDLE so a held-back read strobes right after wr_ack.
      IDLE, DONE: begin
        state_n = IDLE;
        if (wr_en || pend_wr) begin
          go_addr     = pend_wr ? pw_addr : waddr;
          slv_wdata_n = pend_wr ? pw_data : wdata;
          slv_wstrb_n = pend_wr ? pw_strb : wstrb;
          pend_wr_n   = 1'b0;
          if (rd_en) begin
            pend_rd_n = 1'b1;
            pr_addr_n = raddr;
          end
          state_n = WR_WAIT;
        end else if (rd_en || pend_rd) begin
          go_addr   = pend_rd ? pr_addr : raddr;
          pend_rd_n = 1'b0;
          state_n   = RD_WAIT;
        end
        go_sel   = go_addr[SEL_LSB +: 4];
        go_unmap = {1'b0, go_sel} >= NSLV5;
        if (state_n != IDLE) begin
          sel_n      = go_sel;
          unmap_n    = go_unmap;
          tcnt_n     = '0;
          slv_addr_n = go_addr[SEL_LSB-1:0];
          if (!go_unmap) begin
            if (state_n == WR_WAIT) slv_wr_en_n = ONEHOT << go_sel;
            else                    slv_rd_en_n = ONEHOT << go_sel;
          end
        end
      end
      WR_WAIT, RD_WAIT: begin
        if (wr_en) begin
          pend_wr_n = 1'b1;
          pw_addr_n = waddr;
          pw_data_n = wdata;
          pw_strb_n = wstrb;
        end
        if (rd_en) begin
          pend_rd_n = 1'b1;
          pr_addr_n = raddr;
        end
        // An ack in the timeout cycle takes priority over the error completion.
        if (unmap_q || sel_ack || tcnt == TO16) begin
          state_n  = DONE;
          wr_ack_n = (state == WR_WAIT);
          rd_ack_n = (state == RD_WAIT);
          err_inc  = unmap_q || !sel_ack;
          if (state == RD_WAIT) rdata_n = err_inc ? ERR_DATA : sel_rdata;
        end else begin
          tcnt_n = tcnt + 16'd1;
        end
      end
      default: state_n = IDLE;
    endcase

    err_cnt_n = (err_inc && err_cnt != '1) ? err_cnt + 16'd1 : err_cnt;
  end

  always_ff @(posedge s_axi_aclk or posedge s_axi_areset) begin
    if (s_axi_areset) begin
      state     <= IDLE;
      pend_wr   <= 1'b0;
      pend_rd   <= 1'b0;
      pw_addr   <= '0;
      pw_data   <= '0;
      pw_strb   <= '0;
      pr_addr   <= '0;
      sel_q     <= '0;
      unmap_q   <= 1'b0;
      tcnt      <= '0;
      rdata     <= '0;
      wr_ack    <= 1'b0;
      rd_ack    <= 1'b0;
      slv_wr_en <= '0;
      slv_rd_en <= '0;
      slv_addr  <= '0;
      slv_wdata <= '0;
      slv_wstrb <= '0;
      err_cnt   <= '0;
    end else begin
      state     <= state_n;
      pend_wr   <= pend_wr_n;
      pend_rd   <= pend_rd_n;
      pw_addr   <= pw_addr_n;
      pw_data   <= pw_data_n;
      pw_strb   <= pw_strb_n;
      pr_addr   <= pr_addr_n;
      sel_q     <= sel_n;
      unmap_q   <= unmap_n;
      tcnt      <= tcnt_n;
      rdata     <= rdata_n;
      wr_ack    <= wr_ack_n;
      rd_ack    <= rd_ack_n;
      slv_wr_en <= slv_wr_en_n;
      slv_rd_en <= slv_rd_en_n;
      slv_addr  <= slv_addr_n;
      slv_wdata <= slv_wdata_n;
      slv_wstrb <= slv_wstrb_n;
      err_cnt   <= err_cnt_n;
    end
  end

endmodule

// File: tb/tb_reg_bus_decoder.sv
// Bench for reg_bus_decoder: directed and random accesses checked against a
// transaction-level latency/data model, plus a mid-transaction reset.
module tb_reg_bus_decoder;

  localparam int NS = 4;
  localparam int DW = 32;
  localparam int TO = 255;
  localparam logic [31:0] ERR = 32'hDEADBEEF;

  logic             clk = 1'b0;
  logic             rst;
  logic             wr_en, rd_en;
  logic [31:0]      waddr, raddr, wdata;
  logic [3:0]       wstrb;
  logic [31:0]      rdata;
  logic             wr_ack, rd_ack;
  logic [NS-1:0]    slv_wr_en, slv_rd_en;
  logic [11:0]      slv_addr;
  logic [31:0]      slv_wdata;
  logic [3:0]       slv_wstrb;
  logic [NS*DW-1:0] slv_rdata;
  logic [NS-1:0]    slv_wr_ack, slv_rd_ack;
  logic [15:0]      err_cnt;

  int unsigned nvec  = 0;
  int unsigned nfail = 0;
  logic [15:0] exp_err   = '0;
  logic [31:0] exp_rdata = '0;

  always #5 clk = ~clk;

  reg_bus_decoder #(
    .AXI_ADDR_WIDTH(32), .AXI_DATA_WIDTH(32), .N_SLV(NS), .SEL_LSB(12),
    .TIMEOUT(TO), .ERR_DATA(ERR)
  ) dut (
    .s_axi_aclk(clk), .s_axi_areset(rst),
    .wr_en(wr_en), .rd_en(rd_en), .waddr(waddr), .raddr(raddr),
    .wdata(wdata), .wstrb(wstrb), .rdata(rdata), .wr_ack(wr_ack), .rd_ack(rd_ack),
    .slv_wr_en(slv_wr_en), .slv_rd_en(slv_rd_en), .slv_addr(slv_addr),
    .slv_wdata(slv_wdata), .slv_wstrb(slv_wstrb), .slv_rdata(slv_rdata),
    .slv_wr_ack(slv_wr_ack), .slv_rd_ack(slv_rd_ack), .err_cnt(err_cnt)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s observed=%08h expected=%08h", tag, obs, exp);
    end
  endtask

  // Cycles from request (or from the launching cycle) to the ack cycle.
  function automatic int lat(input logic [3:0] sel, input int dly);
    if (sel >= NS) return 2;
    if (dly >= 0 && dly <= TO) return dly + 2;
    return TO + 2;
  endfunction

  function automatic bit is_err(input logic [3:0] sel, input int dly);
    return (sel >= NS) || dly < 0 || dly > TO;
  endfunction

  // dly = slave ack delay after its strobe; negative means the slave never acks.
  task automatic run(input bit dw, input logic [31:0] wa, input logic [31:0] wd,
                     input logic [3:0] ws, input int wdl,
                     input bit dr, input logic [31:0] ra, input logic [31:0] rd,
                     input int rdl);
    logic [3:0] wsel, rsel;
    int wak, rs0, rak, last;
    wsel = wa[15:12];
    rsel = ra[15:12];
    wak  = dw ? lat(wsel, wdl) : -100;
    rs0  = dw ? wak : 0;
    rak  = dr ? rs0 + lat(rsel, rdl) : -100;
    last = ((wak > rak) ? wak : rak) + 1;
    for (int c = 0; c <= last; c++) begin
      @(negedge clk);
      chk("slv_wr_en", 32'(slv_wr_en),
          (dw && c == 1 && wsel < NS) ? (32'd1 << wsel) : 32'd0);
      chk("slv_rd_en", 32'(slv_rd_en),
          (dr && c == rs0 + 1 && rsel < NS) ? (32'd1 << rsel) : 32'd0);
      chk("wr_ack", 32'(wr_ack), 32'(dw && c == wak));
      chk("rd_ack", 32'(rd_ack), 32'(dr && c == rak));
      if (dw && c == 1 && wsel < NS) begin
        chk("slv_addr_wr", 32'(slv_addr), {20'd0, wa[11:0]});
        chk("slv_wdata", slv_wdata, wd);
        chk("slv_wstrb", 32'(slv_wstrb), 32'(ws));
      end
      if (dr && c == rs0 + 1 && rsel < NS)
        chk("slv_addr_rd", 32'(slv_addr), {20'd0, ra[11:0]});
      if (dw && c == wak) begin
        if (is_err(wsel, wdl)) exp_err++;
        chk("err_cnt_wr", 32'(err_cnt), 32'(exp_err));
      end
      if (dr && c == rak) begin
        if (is_err(rsel, rdl)) begin
          exp_err++;
          exp_rdata = ERR;
        end else begin
          exp_rdata = rd;
        end
        chk("err_cnt_rd", 32'(err_cnt), 32'(exp_err));
      end
      chk("rdata", rdata, exp_rdata);

      wr_en = dw && c == 0;
      rd_en = dr && c == 0;
      waddr = wa;
      wdata = wd;
      wstrb = ws;
      raddr = ra;
      slv_wr_ack = NS'($urandom) & ~NS'(32'd1 << wsel);
      slv_rd_ack = NS'($urandom) & ~NS'(32'd1 << rsel);
      for (int i = 0; i < NS; i++) slv_rdata[i*DW +: DW] = $urandom;
      if (dw && wsel < NS && wdl >= 0 && c == 1 + wdl) slv_wr_ack[wsel] = 1'b1;
      if (dr && rsel < NS && rdl >= 0 && c == rs0 + 1 + rdl) begin
        slv_rd_ack[rsel] = 1'b1;
        slv_rdata[int'(rsel)*DW +: DW] = rd;
      end
    end
  endtask

  initial begin
    logic [31:0] a1, a2, d1, d2;
    int r;
    rst = 1'b1;
    wr_en = 1'b0; rd_en = 1'b0;
    waddr = '0; raddr = '0; wdata = '0; wstrb = '0;
    slv_rdata = '0; slv_wr_ack = '0; slv_rd_ack = '0;
    repeat (2) @(negedge clk);
    chk("rst_wr_ack", 32'(wr_ack), 32'd0);
    chk("rst_rd_ack", 32'(rd_ack), 32'd0);
    chk("rst_strobes", 32'({slv_wr_en, slv_rd_en}), 32'd0);
    chk("rst_rdata", rdata, 32'd0);
    chk("rst_err_cnt", 32'(err_cnt), 32'd0);
    rst = 1'b0;

    run(1, 32'h1004, 32'h12345678, 4'hF, 3, 0, 32'h0, 32'h0, 0);
    run(0, 32'h0, 32'h0, 4'h0, 0, 1, 32'h2010, 32'hCAFEF00D, 0);
    run(0, 32'h0, 32'h0, 4'h0, 0, 1, 32'h7000, 32'h0, 0);
    run(1, 32'h3000, 32'hA5A5_0001, 4'h3, -1, 0, 32'h0, 32'h0, 0);
    run(1, 32'h3008, 32'hA5A5_0002, 4'hC, 255, 0, 32'h0, 32'h0, 0);
    run(1, 32'h300C, 32'hA5A5_0003, 4'h1, 254, 0, 32'h0, 32'h0, 0);
    run(0, 32'h0, 32'h0, 4'h0, 0, 1, 32'h3010, 32'h1111_2222, -1);
    run(0, 32'h0, 32'h0, 4'h0, 0, 1, 32'h3014, 32'h3333_4444, 255);
    run(1, 32'h0020, 32'h0BAD_F00D, 4'h5, 2, 1, 32'h1040, 32'h600D_CAFE, 1);
    run(1, 32'h0000, 32'h1357_9BDF, 4'hA, 0, 1, 32'h1FFC, 32'h2468_ACE0, 0);
    run(1, 32'h9000, 32'h5555_AAAA, 4'h6, 0, 1, 32'h2000, 32'h7777_8888, 4);

    for (int n = 0; n < 40; n++) begin
      a1 = $urandom; a1[15:12] = 4'($urandom_range(0, 7));
      a2 = $urandom; a2[15:12] = 4'($urandom_range(0, 7));
      d1 = $urandom; d2 = $urandom;
      r  = $urandom_range(0, 9);
      if (r < 4)
        run(1, a1, d1, 4'($urandom), $urandom_range(0, 6), 0, a2, d2, 0);
      else if (r < 8)
        run(0, a1, d1, 4'h0, 0, 1, a2, d2, $urandom_range(0, 6));
      else
        run(1, a1, d1, 4'($urandom), $urandom_range(0, 6), 1, a2, d2, $urandom_range(0, 6));
    end

    // Reset while a read to region 2 is waiting on an ack that never comes.
    @(negedge clk);
    slv_wr_ack = '0; slv_rd_ack = '0;
    rd_en = 1'b1; raddr = 32'h2040;
    @(negedge clk);
    rd_en = 1'b0;
    chk("pre_rst_rd_en", 32'(slv_rd_en), 32'd4);
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    exp_err   = '0;
    exp_rdata = '0;
    chk("arst_rd_ack", 32'(rd_ack), 32'd0);
    chk("arst_strobes", 32'({slv_wr_en, slv_rd_en}), 32'd0);
    chk("arst_rdata", rdata, 32'd0);
    chk("arst_err_cnt", 32'(err_cnt), 32'd0);
    chk("arst_slv_addr", 32'(slv_addr), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      slv_rd_ack = 4'b0100;
      chk("post_rst_rd_ack", 32'(rd_ack), 32'd0);
      chk("post_rst_strobe", 32'(slv_rd_en), 32'd0);
    end
    run(0, 32'h0, 32'h0, 4'h0, 0, 1, 32'h2018, 32'h0F0F_F0F0, 1);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end

endmodule
